// File: rtl/mu0_sequencer.sv
// rtl/mu0_sequencer.sv - MU0 phase sequencer: FETCH/EXEC1/EXEC2 strobes, condition flags, retire count
// Optional SINGLE_STEP_EN adds a step input and a PAUSE state after each completed instruction.
module mu0_sequencer #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        op,
  input  logic              EXTRA,
  input  logic              acc_en,
  input  logic [DATA_W-1:0] acc_d,
`ifdef SINGLE_STEP_EN
  input  logic              step,
`endif
  output logic              FETCH,
  output logic              EXEC1,
  output logic              EXEC2,
  output logic              EQ,
  output logic              MI,
  output logic              GE,
  output logic              halted,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

`ifdef SINGLE_STEP_EN
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC1, S_EXEC2, S_HALT, S_ILLEGAL, S_PAUSE
  } state_t;
  localparam state_t AFTER_EXEC = S_PAUSE;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_EXEC1, S_EXEC2, S_HALT, S_ILLEGAL
  } state_t;
  localparam state_t AFTER_EXEC = S_FETCH;
`endif

  localparam logic [3:0] OP_STP = 4'h7;

  state_t state;
  state_t state_nxt;
  logic   retire;

  // Opcodes 0xC..0xF are unassigned and trap; STP is checked first but cannot collide.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        state_nxt = S_EXEC1;
      end
      S_EXEC1: begin
        if (op == OP_STP) begin
          state_nxt = S_HALT;
          retire    = 1'b1;
        end else if (op[3:2] == 2'b11) begin
          state_nxt = S_ILLEGAL;
        end else if (EXTRA) begin
          state_nxt = S_EXEC2;
        end else begin
          state_nxt = AFTER_EXEC;
          retire    = 1'b1;
        end
      end
      S_EXEC2: begin
        state_nxt = AFTER_EXEC;
        retire    = 1'b1;
      end
      S_HALT, S_ILLEGAL: begin
        if (start) state_nxt = S_FETCH;
      end
`ifdef SINGLE_STEP_EN
      S_PAUSE: begin
        if (step) state_nxt = S_FETCH;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Strobes and status are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      FETCH   <= 1'b0;
      EXEC1   <= 1'b0;
      EXEC2   <= 1'b0;
      EQ      <= 1'b1;
      MI      <= 1'b0;
      GE      <= 1'b1;
      halted  <= 1'b0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_nxt;
      FETCH   <= (state_nxt == S_FETCH);
      EXEC1   <= (state_nxt == S_EXEC1);
      EXEC2   <= (state_nxt == S_EXEC2);
      halted  <= (state_nxt == S_HALT) || (state_nxt == S_ILLEGAL);
      illegal <= (state_nxt == S_ILLEGAL);
      if (retire) retired <= retired + CNT_W'(1);
      if (acc_en) begin
        EQ <= (acc_d == '0);
        MI <= acc_d[DATA_W-1];
        GE <= ~acc_d[DATA_W-1];
      end
    end
  end

endmodule
